// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Bundles the hazard, branch-redirect, instruction-cache
//               handshake and IF/ID signals of the fetch stage.
//               master = fetch stage side, slave = surrounding pipeline/cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    // hazard / redirect inputs
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    // instruction-cache handshake
    logic        IReqValid;
    logic [15:0] IReqAddr;
    logic        IRespValid;
    logic [15:0] IRespData;
    // IF/ID pipeline register feed
    logic [15:0] InstructionOut;
    logic [15:0] PCOut;
    logic        HltOut;
    logic        NoopOut;
    logic        IFIDWriteEnable;

    modport master (
        input  Stall, BranchTaken, BranchTarget, IRespValid, IRespData,
        output IReqValid, IReqAddr, InstructionOut, PCOut, HltOut, NoopOut,
               IFIDWriteEnable
    );

    modport slave (
        output Stall, BranchTaken, BranchTarget, IRespValid, IRespData,
        input  IReqValid, IReqAddr, InstructionOut, PCOut, HltOut, NoopOut,
               IFIDWriteEnable
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : IF stage of the 16-bit pipelined CPU. Owns the PC, runs the
//               instruction-cache request/response handshake and handles
//               misses, hazard stalls, ID-stage branch redirects and HLT.
//               A bubble (NoopOut=1) is emitted whenever no instruction is
//               delivered in the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_INC     = 16'd2,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    // FETCH  : request issued this cycle at PC
    // MISS   : request outstanding, waiting for the cache
    // REDIR  : request outstanding but its data is dead; jump to redir_pc after
    // HOLD   : word captured while stalled, no request on the bus
    // HALTED : HLT delivered, fetching stopped
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_MISS   = 3'd1,
        S_REDIR  = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] hold_reg;
    logic [15:0] hold_next;
    logic [15:0] redir_pc;
    logic [15:0] redir_next;

    logic        req_valid;     // request driven to the cache this cycle
    logic        deliver;       // a real instruction goes to IF/ID this cycle
    logic [15:0] deliver_word;  // the instruction being delivered
    logic        deliver_hlt;   // delivered word is HLT
    logic [15:0] pc_plus;       // sequential successor, wraps mod 2^16

    assign pc_plus     = pc + PC_INC;
    assign deliver_hlt = (deliver_word[15:12] == HLT_OPCODE);

    // State, PC and capture registers; reset drops any pending request at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            hold_reg <= 16'h0000;
            redir_pc <= 16'h0000;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            hold_reg <= hold_next;
            redir_pc <= redir_next;
        end
    end

    // Next-state decision: branch beats stall and HLT; delivery updates PC last
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        hold_next    = hold_reg;
        redir_next   = redir_pc;
        req_valid    = 1'b0;
        deliver      = 1'b0;
        deliver_word = hold_reg;

        case (state)
            S_FETCH, S_MISS: begin
                req_valid = 1'b1;
                if (bus.BranchTaken) begin
                    // Only a FETCH-cycle hit leaves nothing outstanding; any
                    // miss must drain its request before the redirect lands.
                    if ((state == S_FETCH) && bus.IRespValid) begin
                        pc_next    = bus.BranchTarget;
                        state_next = S_FETCH;
                    end else begin
                        redir_next = bus.BranchTarget;
                        state_next = S_REDIR;
                    end
                end else if (bus.IRespValid) begin
                    if (bus.Stall) begin
                        hold_next  = bus.IRespData;
                        state_next = S_HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_word = bus.IRespData;
                    end
                end else begin
                    state_next = S_MISS;
                end
            end

            S_REDIR: begin
                // Keep the old request on the bus until the cache answers,
                // then throw the data away and jump.
                req_valid = 1'b1;
                if (bus.BranchTaken) begin
                    redir_next = bus.BranchTarget;
                end
                if (bus.IRespValid) begin
                    pc_next    = bus.BranchTaken ? bus.BranchTarget : redir_pc;
                    state_next = S_FETCH;
                end
            end

            S_HOLD: begin
                if (bus.BranchTaken) begin
                    pc_next    = bus.BranchTarget;
                    state_next = S_FETCH;
                end else if (!bus.Stall) begin
                    deliver      = 1'b1;
                    deliver_word = hold_reg;
                end
            end

            S_HALTED: begin
                // Recovery path for an HLT that the ID stage squashes
                if (bus.BranchTaken) begin
                    pc_next    = bus.BranchTarget;
                    state_next = S_FETCH;
                end
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase

        // A delivered HLT freezes the PC; any other word advances it
        if (deliver) begin
            if (deliver_hlt) begin
                state_next = S_HALTED;
            end else begin
                pc_next    = pc_plus;
                state_next = S_FETCH;
            end
        end
    end

    // Outputs; reset suppresses the request and forces a bubble immediately
    always_comb begin
        bus.IReqValid       = req_valid & ~rst;
        bus.IReqAddr        = pc;
        bus.NoopOut         = ~deliver | rst;
        bus.InstructionOut  = (deliver && !rst) ? deliver_word : 16'h0000;
        bus.HltOut          = deliver & deliver_hlt & ~rst;
        bus.PCOut           = pc_plus;
        bus.IFIDWriteEnable = rst ? ~bus.Stall : (~bus.Stall | bus.BranchTaken);
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed scenarios plus a randomized run against a queue-based
//               behavioural model of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: drive just after the rising edge, return at the
    // falling edge so the caller samples mid-cycle.
    task automatic apply(input logic r, input logic st, input logic br,
                         input logic [15:0] tgt, input logic rv,
                         input logic [15:0] rd);
        @(posedge clk);
        #1;
        rst              = r;
        bus.Stall        = st;
        bus.BranchTaken  = br;
        bus.BranchTarget = tgt;
        bus.IRespValid   = rv;
        bus.IRespData    = rd;
        @(negedge clk);
    endtask

    task automatic test_reset;
        apply(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
        checks++; if (bus.IReqValid !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", bus.IReqValid); end
        checks++; if (bus.NoopOut !== 1'b1) begin errors++; $display("FAIL reset_noop: got %b exp 1", bus.NoopOut); end
        checks++; if (bus.InstructionOut !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h exp 0000", bus.InstructionOut); end
        checks++; if (bus.HltOut !== 1'b0) begin errors++; $display("FAIL reset_hlt: got %b exp 0", bus.HltOut); end
        checks++; if (bus.PCOut !== 16'h0002) begin errors++; $display("FAIL reset_pcout: got %h exp 0002", bus.PCOut); end
        checks++; if (bus.IFIDWriteEnable !== 1'b1) begin errors++; $display("FAIL reset_we: got %b exp 1", bus.IFIDWriteEnable); end
        apply(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (bus.IFIDWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we_stall: got %b exp 0", bus.IFIDWriteEnable); end
    endtask

    task automatic test_hits;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] d;
            logic [15:0] a;
            d = 16'h1000 + 16'(i);
            a = 16'(2 * i);
            apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, d);
            checks++; if (bus.IReqValid !== 1'b1 || bus.IReqAddr !== a) begin errors++; $display("FAIL hits_req: got %b/%h exp 1/%h", bus.IReqValid, bus.IReqAddr, a); end
            checks++; if (bus.NoopOut !== 1'b0 || bus.InstructionOut !== d) begin errors++; $display("FAIL hits_instr: got %b/%h exp 0/%h", bus.NoopOut, bus.InstructionOut, d); end
            checks++; if (bus.PCOut !== a + 16'd2) begin errors++; $display("FAIL hits_pcout: got %h exp %h", bus.PCOut, a + 16'd2); end
        end
    endtask

    task automatic test_miss;
        apply(1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0);
        checks++; if (bus.NoopOut !== 1'b1) begin errors++; $display("FAIL miss_branch_noop: got %b exp 1", bus.NoopOut); end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
            checks++; if (bus.IReqValid !== 1'b1 || bus.IReqAddr !== 16'h0010) begin errors++; $display("FAIL miss_req_stable: got %b/%h exp 1/0010", bus.IReqValid, bus.IReqAddr); end
            checks++; if (bus.NoopOut !== 1'b1) begin errors++; $display("FAIL miss_bubble: got %b exp 1", bus.NoopOut); end
        end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h2345);
        checks++; if (bus.NoopOut !== 1'b0 || bus.InstructionOut !== 16'h2345) begin errors++; $display("FAIL miss_deliver: got %b/%h exp 0/2345", bus.NoopOut, bus.InstructionOut); end
        checks++; if (bus.PCOut !== 16'h0012) begin errors++; $display("FAIL miss_pcout: got %h exp 0012", bus.PCOut); end
    endtask

    task automatic test_stall_hold;
        apply(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h3456);
        checks++; if (bus.NoopOut !== 1'b1 || bus.IFIDWriteEnable !== 1'b0) begin errors++; $display("FAIL stall_capture: got noop %b we %b exp 1/0", bus.NoopOut, bus.IFIDWriteEnable); end
        checks++; if (bus.IReqAddr !== 16'h0012) begin errors++; $display("FAIL stall_addr: got %h exp 0012", bus.IReqAddr); end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            checks++; if (bus.IReqValid !== 1'b0 || bus.NoopOut !== 1'b1 || bus.IFIDWriteEnable !== 1'b0) begin errors++; $display("FAIL hold_idle: got req %b noop %b we %b exp 0/1/0", bus.IReqValid, bus.NoopOut, bus.IFIDWriteEnable); end
        end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (bus.NoopOut !== 1'b0 || bus.InstructionOut !== 16'h3456) begin errors++; $display("FAIL hold_release: got %b/%h exp 0/3456", bus.NoopOut, bus.InstructionOut); end
        checks++; if (bus.PCOut !== 16'h0014 || bus.IReqValid !== 1'b0) begin errors++; $display("FAIL hold_release_pc: got %h req %b exp 0014/0", bus.PCOut, bus.IReqValid); end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
        checks++; if (bus.IReqValid !== 1'b1 || bus.IReqAddr !== 16'h0014) begin errors++; $display("FAIL hold_next_addr: got %b/%h exp 1/0014", bus.IReqValid, bus.IReqAddr); end
        checks++; if (bus.InstructionOut !== 16'h1111 || bus.PCOut !== 16'h0016) begin errors++; $display("FAIL hold_next_instr: got %h/%h exp 1111/0016", bus.InstructionOut, bus.PCOut); end
    endtask

    task automatic test_branch_miss;
        apply(1'b0, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0);
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (bus.IReqAddr !== 16'h0020 || bus.NoopOut !== 1'b1) begin errors++; $display("FAIL br_miss_start: got %h/%b exp 0020/1", bus.IReqAddr, bus.NoopOut); end
        apply(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0);
        checks++; if (bus.IFIDWriteEnable !== 1'b1 || bus.NoopOut !== 1'b1) begin errors++; $display("FAIL br_stall_wins: got we %b noop %b exp 1/1", bus.IFIDWriteEnable, bus.NoopOut); end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (bus.IReqValid !== 1'b1 || bus.IReqAddr !== 16'h0020) begin errors++; $display("FAIL br_old_req_held: got %b/%h exp 1/0020", bus.IReqValid, bus.IReqAddr); end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5555);
        checks++; if (bus.NoopOut !== 1'b1 || bus.InstructionOut !== 16'h0000) begin errors++; $display("FAIL br_discard: got %b/%h exp 1/0000", bus.NoopOut, bus.InstructionOut); end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h6666);
        checks++; if (bus.IReqAddr !== 16'h0040 || bus.InstructionOut !== 16'h6666 || bus.PCOut !== 16'h0042) begin errors++; $display("FAIL br_target: got %h/%h/%h exp 0040/6666/0042", bus.IReqAddr, bus.InstructionOut, bus.PCOut); end
    endtask

    task automatic test_hlt_wrap;
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hF000);
        checks++; if (bus.HltOut !== 1'b1 || bus.NoopOut !== 1'b0 || bus.InstructionOut !== 16'hF000) begin errors++; $display("FAIL hlt_deliver: got %b/%b/%h exp 1/0/F000", bus.HltOut, bus.NoopOut, bus.InstructionOut); end
        checks++; if (bus.PCOut !== 16'h0044) begin errors++; $display("FAIL hlt_pcout: got %h exp 0044", bus.PCOut); end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
        checks++; if (bus.IReqValid !== 1'b0 || bus.HltOut !== 1'b0 || bus.NoopOut !== 1'b1) begin errors++; $display("FAIL halted: got req %b hlt %b noop %b exp 0/0/1", bus.IReqValid, bus.HltOut, bus.NoopOut); end
        apply(1'b0, 1'b0, 1'b1, 16'h0080, 1'b0, 16'h0);
        checks++; if (bus.NoopOut !== 1'b1 || bus.IReqValid !== 1'b0) begin errors++; $display("FAIL halted_branch: got noop %b req %b exp 1/0", bus.NoopOut, bus.IReqValid); end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
        checks++; if (bus.IReqAddr !== 16'h0080 || bus.PCOut !== 16'h0082 || bus.NoopOut !== 1'b0) begin errors++; $display("FAIL hlt_resume: got %h/%h/%b exp 0080/0082/0", bus.IReqAddr, bus.PCOut, bus.NoopOut); end
        apply(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0);
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h2222);
        checks++; if (bus.IReqAddr !== 16'hFFFE || bus.PCOut !== 16'h0000) begin errors++; $display("FAIL wrap_top: got %h/%h exp FFFE/0000", bus.IReqAddr, bus.PCOut); end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h3333);
        checks++; if (bus.IReqAddr !== 16'h0000 || bus.PCOut !== 16'h0002) begin errors++; $display("FAIL wrap_zero: got %h/%h exp 0000/0002", bus.IReqAddr, bus.PCOut); end
    endtask

    task automatic test_reset_mid_miss;
        apply(1'b0, 1'b0, 1'b1, 16'h0030, 1'b1, 16'h0);
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (bus.IReqValid !== 1'b1 || bus.IReqAddr !== 16'h0030) begin errors++; $display("FAIL rstmiss_pending: got %b/%h exp 1/0030", bus.IReqValid, bus.IReqAddr); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.IReqValid !== 1'b0 || bus.NoopOut !== 1'b1) begin errors++; $display("FAIL rstmiss_drop: got req %b noop %b exp 0/1", bus.IReqValid, bus.NoopOut); end
        apply(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (bus.IReqValid !== 1'b1 || bus.IReqAddr !== 16'h0000) begin errors++; $display("FAIL rstmiss_restart: got %b/%h exp 1/0000", bus.IReqValid, bus.IReqAddr); end
    endtask

    // Randomized run. The reference keeps the fetch stage as "is there a
    // captured word", "is there a pending redirect", "is a request pending",
    // "are we halted" plus the PC, and applies the rules directly.
    task automatic test_random;
        logic [15:0] m_pc;
        bit          m_halted;
        bit          m_pending;
        logic [15:0] held_q[$];
        logic [15:0] redir_q[$];
        int          shown;
        shown     = 0;
        m_pc      = 16'h0000;
        m_halted  = 1'b0;
        m_pending = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit [31:0]   r1;
            bit [31:0]   r2;
            logic        rc, st, br, rv;
            logic [15:0] tgt, rd, w;
            logic        e_req, e_noop, e_hlt, e_we, do_del;
            logic [15:0] e_addr, e_instr, e_pcout;
            r1  = $urandom;
            r2  = $urandom;
            rc  = (i == 0) || (r1[6:0] == 7'd0);
            st  = (r1[9:8] == 2'b00);
            br  = (r1[13:10] == 4'd0) || (r1[13:10] == 4'd1);
            rv  = (r1[15:14] != 2'b00);
            tgt = r2[31:16] & 16'hFFFE;
            rd  = r2[15:0];
            apply(rc, st, br, tgt, rv, rd);

            do_del  = 1'b0;
            w       = 16'h0000;
            e_noop  = 1'b1;
            e_instr = 16'h0000;
            e_hlt   = 1'b0;
            if (rc) begin
                m_pc      = 16'h0000;
                m_halted  = 1'b0;
                m_pending = 1'b0;
                held_q.delete();
                redir_q.delete();
                e_req   = 1'b0;
                e_addr  = m_pc;
                e_pcout = 16'h0002;
                e_we    = ~st;
            end else begin
                e_req   = !m_halted && (held_q.size() == 0);
                e_addr  = m_pc;
                e_pcout = m_pc + 16'd2;
                e_we    = ~st | br;
                if (br) begin
                    if (m_halted || held_q.size() != 0) begin
                        m_pc = tgt; m_halted = 1'b0; held_q.delete();
                    end else if (redir_q.size() != 0) begin
                        redir_q.delete();
                        if (rv) begin m_pc = tgt; m_pending = 1'b0; end
                        else redir_q.push_back(tgt);
                    end else if (m_pending || !rv) begin
                        redir_q.push_back(tgt); m_pending = 1'b1;
                    end else begin
                        m_pc = tgt;
                    end
                end else if (m_halted) begin
                    m_halted = 1'b1;
                end else if (held_q.size() != 0) begin
                    if (!st) begin do_del = 1'b1; w = held_q.pop_front(); end
                end else if (redir_q.size() != 0) begin
                    if (rv) begin m_pc = redir_q.pop_front(); m_pending = 1'b0; end
                end else if (rv) begin
                    m_pending = 1'b0;
                    if (st) held_q.push_back(rd);
                    else begin do_del = 1'b1; w = rd; end
                end else begin
                    m_pending = 1'b1;
                end
                if (do_del) begin
                    e_noop  = 1'b0;
                    e_instr = w;
                    if (w[15:12] == 4'hF) begin e_hlt = 1'b1; m_halted = 1'b1; end
                    else m_pc = m_pc + 16'd2;
                end
            end

            checks++; if (bus.IReqValid !== e_req) begin errors++; if (shown < 20) $display("FAIL rand_req cyc %0d: got %b exp %b", i, bus.IReqValid, e_req); shown++; end
            if (e_req) begin
                checks++; if (bus.IReqAddr !== e_addr) begin errors++; if (shown < 20) $display("FAIL rand_addr cyc %0d: got %h exp %h", i, bus.IReqAddr, e_addr); shown++; end
            end
            checks++; if (bus.NoopOut !== e_noop || bus.InstructionOut !== e_instr) begin errors++; if (shown < 20) $display("FAIL rand_instr cyc %0d: got %b/%h exp %b/%h", i, bus.NoopOut, bus.InstructionOut, e_noop, e_instr); shown++; end
            checks++; if (bus.HltOut !== e_hlt) begin errors++; if (shown < 20) $display("FAIL rand_hlt cyc %0d: got %b exp %b", i, bus.HltOut, e_hlt); shown++; end
            checks++; if (bus.IFIDWriteEnable !== e_we) begin errors++; if (shown < 20) $display("FAIL rand_we cyc %0d: got %b exp %b", i, bus.IFIDWriteEnable, e_we); shown++; end
            if (!e_noop || rc) begin
                checks++; if (bus.PCOut !== e_pcout) begin errors++; if (shown < 20) $display("FAIL rand_pcout cyc %0d: got %h exp %h", i, bus.PCOut, e_pcout); shown++; end
            end
        end
    endtask

    initial begin
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 16'h0000;
        bus.IRespValid   = 1'b0;
        bus.IRespData    = 16'h0000;
        test_reset();
        test_hits();
        test_miss();
        test_stall_hold();
        test_branch_miss();
        test_hlt_wrap();
        test_reset_mid_miss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
